// File: rtl/shift_arb_pkg.sv
// rtl/shift_arb_pkg.sv - shared types and widths for the shift register arbiter
package shift_arb_pkg;

    localparam int DATA_W    = 8;
    localparam int ACK_CNT_W = 8;
    localparam int GAP_CNT_W = 8;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_LOW  = 3'd2,
        S_WAIT_HIGH = 3'd3,
        S_GAP       = 3'd4
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin winner search starting after the last winner
module rr_pick
    import shift_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] index,
    output logic             valid
);

    int k;

    // Scan last+1, last+2, ... wrapping back to last; first requester found wins.
    always_comb begin
        grant = '0;
        index = '0;
        valid = 1'b0;
        k     = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            k = (int'(last) + i) % N_REQ;
            if (!valid && req[k]) begin
                valid    = 1'b1;
                index    = IDX_W'(k);
                grant[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - round-robin sharing of one serial shifter among several requesters
module shift_arbiter
    import shift_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int ACK_WAIT   = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [N_REQ-1:0]        i_req,
    input  logic [DATA_W*N_REQ-1:0] i_data,
    output logic [N_REQ-1:0]        o_grant,
    output logic [N_REQ-1:0]        o_done,
    output logic                    o_fault,
    output logic                    o_busy,
    input  logic                    i_ready,
    output logic [DATA_W-1:0]       o_data,
    output logic                    o_enable
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [ACK_CNT_W-1:0] ACK_LAST = ACK_CNT_W'(ACK_WAIT - 1);
    localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t               state, state_nx;
    logic [IDX_W-1:0]     ptr, ptr_nx;
    logic [ACK_CNT_W-1:0] ack_cnt, ack_cnt_nx;
    logic [GAP_CNT_W-1:0] gap_cnt, gap_cnt_nx;
    logic [N_REQ-1:0]     grant_nx, done_nx;
    logic                 fault_nx, busy_nx, enable_nx;
    logic [DATA_W-1:0]    data_nx;

    logic [N_REQ-1:0]     pick_grant;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_valid;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req   (i_req),
        .last  (ptr),
        .grant (pick_grant),
        .index (pick_idx),
        .valid (pick_valid)
    );

    // State, counters and every output are registered; reset parks the pointer so requester 0 wins first.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= S_IDLE;
            ptr      <= IDX_W'(N_REQ - 1);
            ack_cnt  <= '0;
            gap_cnt  <= '0;
            o_grant  <= '0;
            o_done   <= '0;
            o_fault  <= 1'b0;
            o_busy   <= 1'b0;
            o_enable <= 1'b0;
            o_data   <= '0;
        end else begin
            state    <= state_nx;
            ptr      <= ptr_nx;
            ack_cnt  <= ack_cnt_nx;
            gap_cnt  <= gap_cnt_nx;
            o_grant  <= grant_nx;
            o_done   <= done_nx;
            o_fault  <= fault_nx;
            o_busy   <= busy_nx;
            o_enable <= enable_nx;
            o_data   <= data_nx;
        end
    end

    // Next-state and next-output decode; done/fault/enable are pulses and default low.
    always_comb begin
        state_nx   = state;
        ptr_nx     = ptr;
        ack_cnt_nx = ack_cnt;
        gap_cnt_nx = gap_cnt;
        grant_nx   = o_grant;
        done_nx    = '0;
        fault_nx   = 1'b0;
        enable_nx  = 1'b0;
        data_nx    = o_data;
        case (state)
            S_IDLE: begin
                if (i_ready && pick_valid) begin
                    data_nx   = i_data[DATA_W*int'(pick_idx) +: DATA_W];
                    grant_nx  = pick_grant;
                    enable_nx = 1'b1;
                    ptr_nx    = pick_idx;
                    state_nx  = S_START;
                end
            end
            S_START: begin
                ack_cnt_nx = '0;
                state_nx   = S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
                if (!i_ready) begin
                    state_nx = S_WAIT_HIGH;
                end else if (ack_cnt == ACK_LAST) begin
                    fault_nx   = 1'b1;
                    grant_nx   = '0;
                    gap_cnt_nx = '0;
                    state_nx   = S_GAP;
                end else begin
                    ack_cnt_nx = ack_cnt + 1'b1;
                end
            end
            S_WAIT_HIGH: begin
                if (i_ready) begin
                    done_nx    = o_grant;
                    grant_nx   = '0;
                    gap_cnt_nx = '0;
                    state_nx   = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nx = S_IDLE;
                end else begin
                    gap_cnt_nx = gap_cnt + 1'b1;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
        busy_nx = (state_nx != S_IDLE);
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - randomized bench for shift_arbiter against a transaction-timing model
module tb_shift_arbiter;

    localparam int N   = 4;
    localparam int AW  = 4;
    localparam int GAP = 2;
    localparam int G   = (GAP == 0) ? 1 : GAP;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [8*N-1:0] data;
    logic           ready;
    logic [N-1:0]   o_grant, o_done;
    logic           o_fault, o_busy, o_enable;
    logic [7:0]     o_data;

    always #5 clk = ~clk;

    shift_arbiter #(
        .N_REQ      (N),
        .ACK_WAIT   (AW),
        .GAP_CYCLES (GAP)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_req    (req),
        .i_data   (data),
        .o_grant  (o_grant),
        .o_done   (o_done),
        .o_fault  (o_fault),
        .o_busy   (o_busy),
        .i_ready  (ready),
        .o_data   (o_data),
        .o_enable (o_enable)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // transaction model: enable cycle, completion cycle, shifter ack delay and busy length
    int         e_cyc, c_cyc, idle_from, d_ack, l_busy, last, win;
    bit         fault_x, in_reset;
    logic [7:0] exp_data;
    logic [N-1:0]   prev_req;
    logic [8*N-1:0] prev_data;
    bit         prev_ready;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic int rr_winner(input logic [N-1:0] r, input int from);
        for (int i = 1; i <= N; i++) begin
            if (r[(from + i) % N]) return (from + i) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        e_cyc = -1000; c_cyc = -1000; idle_from = 0;
        last = N - 1; win = -1; fault_x = 1'b0; exp_data = 8'h00;
        in_reset = 1'b1;
        req = '0; ready = 1'b1;
        prev_req = '0; prev_ready = 1'b1; prev_data = data;
    endtask

    task automatic release_reset(input logic [N-1:0] r0, input logic [7:0] d0);
        rst_n = 1'b1;
        in_reset = 1'b0;
        idle_from = cyc;
        req = r0;
        data[7:0] = d0;
        ready = 1'b1;
        prev_req = req; prev_ready = ready; prev_data = data;
    endtask

    task automatic step(input int p_raise, input int p_drop, input int p_outage);
        bit exp_en;
        logic [N-1:0] oh;
        @(posedge clk);
        #1;
        cyc++;
        exp_en = !in_reset && (cyc - 1 >= idle_from) && prev_ready && (prev_req != '0);
        if (exp_en) begin
            win = rr_winner(prev_req, last);
            last = win;
            e_cyc = cyc;
            exp_data = prev_data[8*win +: 8];
            d_ack = $urandom_range(1, AW + 1);
            l_busy = $urandom_range(1, 8);
            fault_x = (d_ack > AW);
            c_cyc = fault_x ? e_cyc + AW + 1 : e_cyc + d_ack + l_busy + 1;
            idle_from = c_cyc + G;
        end
        oh = '0;
        if (win >= 0) oh[win] = 1'b1;
        check_eq("enable", o_enable, exp_en);
        check_eq("grant", o_grant, (cyc >= e_cyc && cyc < c_cyc) ? oh : '0);
        check_eq("done", o_done, (!fault_x && cyc == c_cyc) ? oh : '0);
        check_eq("fault", o_fault, fault_x && cyc == c_cyc);
        check_eq("busy", o_busy, cyc >= e_cyc && cyc < c_cyc + G);
        check_eq("data", o_data, exp_data);

        if (!in_reset) begin
            for (int k = 0; k < N; k++) begin
                if (req[k]) begin
                    if (k == win && cyc == c_cyc) begin
                        req[k] = ($urandom_range(0, 99) < p_raise);
                        if (req[k]) data[8*k +: 8] = 8'($urandom);
                    end else if (k == win && cyc >= e_cyc && cyc < c_cyc) begin
                        if ($urandom_range(0, 99) < p_drop) req[k] = 1'b0;
                    end else if ($urandom_range(0, 199) < p_drop) begin
                        req[k] = 1'b0;
                    end
                end else if ($urandom_range(0, 99) < p_raise) begin
                    req[k] = 1'b1;
                    data[8*k +: 8] = 8'($urandom);
                end
            end
            if (cyc >= e_cyc && cyc < c_cyc)
                ready = !(!fault_x && cyc >= e_cyc + d_ack && cyc < e_cyc + d_ack + l_busy);
            else
                ready = ($urandom_range(0, 99) >= p_outage);
        end else begin
            ready = 1'b1;
        end
        prev_req = req; prev_ready = ready; prev_data = data;
    endtask

    initial begin
        bit found;
        rst_n = 1'b1;
        data = '0;
        model_reset();
        #2 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        release_reset('0, 8'h00);

        // first request: requester 0 alone
        release_reset(4'b0001, 8'h55);
        for (int i = 0; i < 400; i++) step(40, 5, 15);

        // every requester held: strict 0,1,2,3 rotation
        for (int i = 0; i < 300; i++) step(100, 0, 0);

        // reach WAIT_HIGH, then assert reset asynchronously mid-transfer
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            step(60, 0, 0);
            if (!fault_x && cyc > e_cyc + d_ack && cyc <= e_cyc + d_ack + l_busy) found = 1'b1;
        end
        check_eq("wait_high_reached", found, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("arst_grant", o_grant, '0);
        check_eq("arst_done", o_done, '0);
        check_eq("arst_fault", o_fault, 1'b0);
        check_eq("arst_busy", o_busy, 1'b0);
        check_eq("arst_enable", o_enable, 1'b0);
        check_eq("arst_data", o_data, 8'h00);
        model_reset();
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        release_reset(4'b0001, 8'hA5);
        for (int i = 0; i < 400; i++) step(20, 10, 30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one 8-bit serial shifter (74HC595 driver with `enable`/`ready` handshake) among N_REQ independent requesters.
- Arbitrates round-robin and drives the shifter's data byte and one-cycle start pulse.
- Waits for the shift to complete, then returns a per-requester done pulse.
- Sits between application-level producers (LED/status writers) and the single shift-register driver.

Parameters:
N_REQ, 4, number of requesters (2..8)
ACK_WAIT, 4, max cycles in WAIT_LOW for shifter ready to drop after start before declaring fault
GAP_CYCLES, 2, idle cycles enforced between consecutive transfers (0 allowed)

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  reset; one clock; reset is asynchronous and active-low
i_req  in  N_REQ  per-requester request level; held high until matching o_done/o_fault
i_data  in  8*N_REQ  requester k byte at bits [8k+7:8k]; must be stable while i_req[k] high
o_grant  out  N_REQ  one-hot, high from START through completion of requester's transfer
o_done  out  N_REQ  one-cycle pulse on successful transfer completion
o_fault  out  1  one-cycle pulse when shifter never acknowledged
o_busy  out  1  high in any state other than IDLE
i_ready  in  1  shifter idle/ready
o_data  out  8  byte to shifter; registered, held from START until next grant
o_enable  out  1  one-cycle start pulse to shifter

Behaviour:
- Reset (async assert, sync release): state IDLE; o_grant=0, o_done=0, o_fault=0, o_busy=0, o_enable=0, o_data=8'h00; RR pointer = N_REQ-1 so requester 0 wins first.
- All outputs registered.
- States: IDLE, START, WAIT_LOW, WAIT_HIGH, GAP.
- IDLE:
  - Proceed only if i_ready=1 and |i_req.
  - Winner = first set bit searching last+1, last+2, ... wrapping to last.
  - Next edge: o_data <= winner's byte, o_grant <= one-hot(winner), o_enable <= 1, pointer <= winner, state START.
  - If i_ready=0 with requests pending, stay in IDLE and issue nothing.
- START (exactly 1 cycle, o_enable=1): next edge o_enable <= 0, clear ack counter, go WAIT_LOW.
- WAIT_LOW:
  - If i_ready=0, go WAIT_HIGH.
  - Else increment counter. When counter reaches ACK_WAIT-1 with i_ready still 1: pulse o_fault, clear o_grant, go GAP. No o_done in this case.
- WAIT_HIGH:
  - Wait with no limit.
  - On i_ready=1: o_done[winner] <= 1 for one cycle, clear o_grant simultaneously, go GAP. The done pulse and cleared grant are visible in the first GAP cycle.
- GAP:
  - Count GAP_CYCLES cycles, then IDLE.
  - With GAP_CYCLES=0, go straight to IDLE; minimum 1 cycle still spent in GAP, where the done pulse is presented.
- Latency, single request, instant-ack shifter: req sampled at T, o_enable at T+1. Fastest done is visible 3 cycles after the enable pulse.
- Requester dropping i_req:
  - Before grant: ignored.
  - After grant: transfer completes; done/fault still pulses.
- Request re-asserted in the same cycle as its o_done: treated as a new request in the next IDLE, subject to RR order.
- o_data holds the last sent byte when idle.
- Async reset mid-transfer: returns to reset values immediately; an in-flight done is lost. Requesters must re-request.

Decomposition:
- Package shift_arb_pkg: state encoding (5 states, 3-bit), DATA_W=8, localparam widths for the ack and gap counters.
- Sub-module rr_pick (combinational): inputs req vector and last-winner index; outputs one-hot grant, index, and valid.
- Only rr_pick is split out; the FSM stays in shift_arbiter.

Test Plan:
- Reset, then i_req=4'b0001, data0=8'h55, shifter drops ready 1 cycle after enable for 8 cycles → o_data=8'h55; single-cycle o_enable; o_done[0] pulses once; o_grant=0 afterwards.
- i_req=4'b1111 held with data 8'h11,8'h22,8'h33,8'h44 → grants in order 0,1,2,3,0; o_data sequence 11,22,33,44,11; ≥GAP_CYCLES idle cycles between transfers.
- Shifter model ignores enable (i_ready stuck 1), i_req=4'b0100 → o_fault pulses ACK_WAIT+1 cycles after o_enable; no o_done; RR then moves to requester 3 if requesting.
- i_ready=0 while i_req=4'b0010 → no o_enable until i_ready=1; then normal transfer.
- Requester 1 drops i_req in WAIT_HIGH → transfer completes; o_done[1] still pulses exactly once.
- Assert i_rst_n=0 during WAIT_HIGH → all outputs 0 within the same cycle; after release with i_req=4'b0001, requester 0 is served first.
